// File: rtl/spi_chain_node.sv
// SPI mode-0 daisy-chain node: oversampled host SPI is forwarded downstream and
// chip-addressed frames are decoded into a byte-wide register bus.
module spi_chain_node #(
  parameter int ID_W        = 4,
  parameter int ADDR_W      = 7,
  parameter int SYNC_STAGES = 2
) (
  input  logic              SPI_CLK,
  input  logic              SPI_CLK_RESET_N,
  input  logic [ID_W-1:0]   CHIP_ID,
  input  logic              SCSN_fromHost,
  input  logic              SCLK_fromHost,
  input  logic              MOSI_fromHost,
  output logic              MISO_toHost,
  output logic              SCSN_toClient,
  output logic              SCLK_toClient,
  output logic              MOSI_toClient,
  input  logic              MISO_fromClient,
  input  logic              IRQ_fromClient,
  input  logic              irq_local,
  output logic              IRQ_toHost,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [7:0]        reg_wdata,
  output logic              reg_we,
  output logic              reg_re,
  input  logic [7:0]        reg_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_ID, S_CMD, S_DATA} state_t;

  localparam logic [ID_W-1:0]   ID_BCAST = {ID_W{1'b1}};
  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  logic [SYNC_STAGES-1:0] scsn_sync_q, sclk_sync_q, mosi_sync_q;
  logic s_scsn, s_sclk, s_mosi;
  logic scsn_prev_q, sclk_prev_q;
  logic scsn_fwd_q, sclk_fwd_q, mosi_fwd_q;
  logic irq_q;

  state_t state_q, state_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [7:0]        shin_q, shin_d;
  logic [7:0]        shout_q, shout_d;
  logic              shift_en_q, shift_en_d;
  logic              sel_q, sel_d;
  logic              bcast_q, bcast_d;
  logic              rnw_q, rnw_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] reg_addr_q, reg_addr_d;
  logic [7:0]        reg_wdata_q, reg_wdata_d;
  logic              reg_we_q, reg_we_d;
  logic              reg_re_q, reg_re_d;
  logic              rd_pend_q, rd_pend_d;

  logic sclk_rise, sclk_fall, scsn_fall, scsn_rise;
  logic active, byte_done, id_done, cmd_done, data_done;
  logic wr_strobe, rd_first, rd_next, read_active;
  logic [7:0] byte_next;

  // Synchronisers; SCSN idles high so its chain resets to ones.
  always_ff @(posedge SPI_CLK or negedge SPI_CLK_RESET_N) begin
    if (!SPI_CLK_RESET_N) begin
      scsn_sync_q <= '1;
      sclk_sync_q <= '0;
      mosi_sync_q <= '0;
      scsn_prev_q <= 1'b1;
      sclk_prev_q <= 1'b0;
      scsn_fwd_q  <= 1'b1;
      sclk_fwd_q  <= 1'b0;
      mosi_fwd_q  <= 1'b0;
      irq_q       <= 1'b0;
    end else begin
      scsn_sync_q <= {scsn_sync_q[SYNC_STAGES-2:0], SCSN_fromHost};
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], SCLK_fromHost};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], MOSI_fromHost};
      scsn_prev_q <= s_scsn;
      sclk_prev_q <= s_sclk;
      scsn_fwd_q  <= s_scsn;
      sclk_fwd_q  <= s_sclk;
      mosi_fwd_q  <= s_mosi;
      irq_q       <= irq_local | IRQ_fromClient;
    end
  end

  assign s_scsn    = scsn_sync_q[SYNC_STAGES-1];
  assign s_sclk    = sclk_sync_q[SYNC_STAGES-1];
  assign s_mosi    = mosi_sync_q[SYNC_STAGES-1];
  assign sclk_rise = s_sclk & ~sclk_prev_q;
  assign sclk_fall = ~s_sclk & sclk_prev_q;
  assign scsn_fall = ~s_scsn & scsn_prev_q;
  assign scsn_rise = s_scsn & ~scsn_prev_q;

  // FSM state register
  always_ff @(posedge SPI_CLK or negedge SPI_CLK_RESET_N) begin
    if (!SPI_CLK_RESET_N) state_q <= S_IDLE;
    else                  state_q <= state_d;
  end

  // FSM next state; a byte completing together with SCSN rising still ends the frame
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (scsn_fall) state_d = S_ID;
      S_ID:    if (byte_done) state_d = S_CMD;
      S_CMD:   if (byte_done) state_d = S_DATA;
      S_DATA:  state_d = S_DATA;
      default: state_d = S_IDLE;
    endcase
    if (state_q != S_IDLE && scsn_rise) state_d = S_IDLE;
  end

  // FSM outputs: per-cycle decode of byte boundaries and bus strobes
  always_comb begin
    active      = (state_q != S_IDLE);
    byte_next   = {shin_q[6:0], s_mosi};
    byte_done   = active & sclk_rise & (bit_cnt_q == 3'd7);
    id_done     = byte_done & (state_q == S_ID);
    cmd_done    = byte_done & (state_q == S_CMD);
    data_done   = byte_done & (state_q == S_DATA);
    wr_strobe   = data_done & (sel_q | bcast_q) & ~rnw_q;
    rd_first    = cmd_done & sel_q & byte_next[7];
    rd_next     = data_done & sel_q & rnw_q;
    read_active = (state_q == S_DATA) & sel_q & rnw_q;
  end

  always_comb begin
    bit_cnt_d   = bit_cnt_q;
    shin_d      = shin_q;
    shout_d     = shout_q;
    shift_en_d  = shift_en_q;
    sel_d       = sel_q;
    bcast_d     = bcast_q;
    rnw_d       = rnw_q;
    addr_d      = addr_q;
    reg_addr_d  = reg_addr_q;
    reg_wdata_d = reg_wdata_q;
    reg_we_d    = 1'b0;
    reg_re_d    = 1'b0;
    rd_pend_d   = reg_re_q;

    if (!active) begin
      bit_cnt_d = 3'd0;
    end else if (sclk_rise) begin
      bit_cnt_d  = bit_cnt_q + 3'd1;
      shin_d     = byte_next;
      shift_en_d = (bit_cnt_q != 3'd7);
    end

    // No shift on the falling edge after the 8th rising edge: the prefetch lands there
    if (sclk_fall) begin
      shift_en_d = 1'b0;
      if (shift_en_q && read_active) shout_d = {shout_q[6:0], 1'b0};
    end
    if (rd_pend_q) shout_d = reg_rdata;

    if (id_done) begin
      sel_d   = (byte_next[ID_W-1:0] == CHIP_ID);
      bcast_d = (byte_next[ID_W-1:0] == ID_BCAST);
    end
    if (cmd_done) begin
      rnw_d  = byte_next[7];
      addr_d = byte_next[ADDR_W-1:0];
      if (rd_first) begin
        reg_re_d   = 1'b1;
        reg_addr_d = byte_next[ADDR_W-1:0];
      end
    end
    if (wr_strobe) begin
      reg_we_d    = 1'b1;
      reg_addr_d  = addr_q;
      reg_wdata_d = byte_next;
      addr_d      = addr_q + ADDR_ONE;
    end
    if (rd_next) begin
      reg_re_d   = 1'b1;
      reg_addr_d = addr_q + ADDR_ONE;
      addr_d     = addr_q + ADDR_ONE;
    end

    if (active && scsn_rise) begin
      sel_d      = 1'b0;
      bcast_d    = 1'b0;
      rnw_d      = 1'b0;
      shift_en_d = 1'b0;
    end
  end

  always_ff @(posedge SPI_CLK or negedge SPI_CLK_RESET_N) begin
    if (!SPI_CLK_RESET_N) begin
      bit_cnt_q   <= 3'd0;
      shin_q      <= 8'd0;
      shout_q     <= 8'd0;
      shift_en_q  <= 1'b0;
      sel_q       <= 1'b0;
      bcast_q     <= 1'b0;
      rnw_q       <= 1'b0;
      addr_q      <= '0;
      reg_addr_q  <= '0;
      reg_wdata_q <= 8'd0;
      reg_we_q    <= 1'b0;
      reg_re_q    <= 1'b0;
      rd_pend_q   <= 1'b0;
    end else begin
      bit_cnt_q   <= bit_cnt_d;
      shin_q      <= shin_d;
      shout_q     <= shout_d;
      shift_en_q  <= shift_en_d;
      sel_q       <= sel_d;
      bcast_q     <= bcast_d;
      rnw_q       <= rnw_d;
      addr_q      <= addr_d;
      reg_addr_q  <= reg_addr_d;
      reg_wdata_q <= reg_wdata_d;
      reg_we_q    <= reg_we_d;
      reg_re_q    <= reg_re_d;
      rd_pend_q   <= rd_pend_d;
    end
  end

  // MISO is held low while in reset so the host never sees a floating client line
  assign MISO_toHost   = SPI_CLK_RESET_N & (read_active ? shout_q[7] : MISO_fromClient);
  assign SCSN_toClient = scsn_fwd_q;
  assign SCLK_toClient = sclk_fwd_q;
  assign MOSI_toClient = mosi_fwd_q;
  assign IRQ_toHost    = irq_q;
  assign reg_addr      = reg_addr_q;
  assign reg_wdata     = reg_wdata_q;
  assign reg_we        = reg_we_q;
  assign reg_re        = reg_re_q;

endmodule

// File: tb/tb_spi_chain_node.sv
// Frame-level bench for spi_chain_node: table of frames plus corner-case sequences,
// with a strobe scoreboard and a forwarding-latency monitor.
`timescale 1ns/1ps
module tb_spi_chain_node;
  localparam int SYNC = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] chip_id = 4'h3;
  logic       scsn = 1'b1, sclk = 1'b0, mosi = 1'b0;
  logic       miso_to_host, scsn_cli, sclk_cli, mosi_cli;
  logic       miso_cli = 1'b0, irq_cli = 1'b0, irq_loc = 1'b0;
  logic       irq_host;
  logic [6:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_we, reg_re;
  logic [7:0] reg_rdata = 8'h00;

  spi_chain_node #(.ID_W(4), .ADDR_W(7), .SYNC_STAGES(SYNC)) dut (
    .SPI_CLK(clk), .SPI_CLK_RESET_N(rst_n), .CHIP_ID(chip_id),
    .SCSN_fromHost(scsn), .SCLK_fromHost(sclk), .MOSI_fromHost(mosi),
    .MISO_toHost(miso_to_host), .SCSN_toClient(scsn_cli), .SCLK_toClient(sclk_cli),
    .MOSI_toClient(mosi_cli), .MISO_fromClient(miso_cli), .IRQ_fromClient(irq_cli),
    .irq_local(irq_loc), .IRQ_toHost(irq_host), .reg_addr(reg_addr),
    .reg_wdata(reg_wdata), .reg_we(reg_we), .reg_re(reg_re), .reg_rdata(reg_rdata)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] rom(input logic [6:0] a);
    logic [7:0] t;
    t = {1'b0, a};
    if (a == 7'd5) return 8'h3C;
    if (a == 7'd6) return 8'hC3;
    return t * 8'd3 + 8'd1;
  endfunction

  function automatic logic [15:0] mkw(input logic [6:0] a, input logic [7:0] d);
    return {1'b1, a, d};
  endfunction
  function automatic logic [15:0] mkr(input logic [6:0] a);
    return {1'b0, a, 8'h00};
  endfunction

  // Core model: read data one cycle after the strobe
  always @(posedge clk) if (reg_re) reg_rdata <= rom(reg_addr);

  logic [15:0] exp_q[$];
  always @(negedge clk) begin
    if (rst_n) begin
      if (reg_we && reg_re) check("we_re_exclusive", 32'd1, 32'd0);
      if (reg_we || reg_re) begin
        if (exp_q.size() == 0) begin
          check("unexpected_strobe", {15'd0, 1'b1, reg_we, reg_addr, reg_wdata}, 32'd0);
        end else begin
          logic [15:0] e;
          e = exp_q.pop_front();
          check("strobe_kind", {31'd0, reg_we}, {31'd0, e[15]});
          check("strobe_addr", {25'd0, reg_addr}, {25'd0, e[14:8]});
          if (e[15]) check("strobe_wdata", {24'd0, reg_wdata}, {24'd0, e[7:0]});
          $display("strobe %s addr=0x%02h data=0x%02h", reg_we ? "WR" : "RD", reg_addr,
                   reg_we ? reg_wdata : reg_rdata);
        end
      end
    end
  end

  // Forwarded lines must equal the inputs seen SYNC+1 clocks earlier
  logic [2:0] hist [0:SYNC];
  int fwd_valid = 0;
  always @(posedge clk) begin
    if (!rst_n) fwd_valid = 0;
    else begin
      for (int k = SYNC; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = {scsn, sclk, mosi};
      if (fwd_valid < SYNC + 1) fwd_valid++;
    end
  end
  always @(negedge clk)
    if (rst_n && fwd_valid == SYNC + 1)
      check("fwd_latency", {29'd0, scsn_cli, sclk_cli, mosi_cli}, {29'd0, hist[SYNC]});

  task automatic half();
    repeat (4) @(negedge clk);
  endtask

  task automatic spi_byte(input logic [7:0] tx, input logic [7:0] cli, input int nbits,
                          input bit cs_on_last, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 7; i >= 8 - nbits; i--) begin
      mosi = tx[i];
      miso_cli = cli[i];
      half();
      rx[i] = miso_to_host;
      sclk = 1'b1;
      if (cs_on_last && i == 0) scsn = 1'b1;
      half();
      sclk = 1'b0;
    end
  endtask

  task automatic frame(input logic [7:0] id, input logic [7:0] cmd, input int nb,
                       input logic [7:0] d0, input logic [7:0] d1,
                       input logic [7:0] c0, input logic [7:0] c1,
                       output logic [7:0] m0, output logic [7:0] m1);
    logic [7:0] dummy;
    m0 = 8'h00;
    m1 = 8'h00;
    scsn = 1'b0;
    half();
    spi_byte(id, 8'h00, 8, 1'b0, dummy);
    spi_byte(cmd, 8'h00, 8, 1'b0, dummy);
    if (nb > 0) spi_byte(d0, c0, 8, 1'b0, m0);
    if (nb > 1) spi_byte(d1, c1, 8, 1'b0, m1);
    half();
    scsn = 1'b1;
    miso_cli = 1'b0;
    mosi = 1'b0;
    half();
    half();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_scsn_cli"}, {31'd0, scsn_cli}, 32'd1);
    check({tag, "_sclk_cli"}, {31'd0, sclk_cli}, 32'd0);
    check({tag, "_mosi_cli"}, {31'd0, mosi_cli}, 32'd0);
    check({tag, "_miso_host"}, {31'd0, miso_to_host}, 32'd0);
    check({tag, "_irq_host"}, {31'd0, irq_host}, 32'd0);
    check({tag, "_reg_we"}, {31'd0, reg_we}, 32'd0);
    check({tag, "_reg_re"}, {31'd0, reg_re}, 32'd0);
    check({tag, "_reg_addr"}, {25'd0, reg_addr}, 32'd0);
    check({tag, "_reg_wdata"}, {24'd0, reg_wdata}, 32'd0);
  endtask

  typedef struct {
    logic [7:0]  id, cmd;
    int          nb;
    logic [7:0]  d0, d1, cli0, cli1, miso0, miso1;
    int          nstb;
    logic [15:0] s0, s1, s2;
  } vec_t;

  vec_t vec[8];

  initial begin
    logic [7:0] m0, m1, dummy;

    vec[0] = '{8'h03, 8'h05, 2, 8'hA5, 8'h5A, 8'h00, 8'h00, 8'h00, 8'h00, 2,
               mkw(7'h05, 8'hA5), mkw(7'h06, 8'h5A), 16'h0};
    vec[1] = '{8'h03, 8'h85, 2, 8'h00, 8'h00, 8'h00, 8'h00, 8'h3C, 8'hC3, 3,
               mkr(7'h05), mkr(7'h06), mkr(7'h07)};
    vec[2] = '{8'h02, 8'h85, 2, 8'h00, 8'h00, 8'hA6, 8'h59, 8'hA6, 8'h59, 0,
               16'h0, 16'h0, 16'h0};
    vec[3] = '{8'h0F, 8'h7F, 2, 8'h11, 8'h22, 8'h00, 8'h00, 8'h00, 8'h00, 2,
               mkw(7'h7F, 8'h11), mkw(7'h00, 8'h22), 16'h0};
    vec[4] = '{8'h0F, 8'h85, 2, 8'h00, 8'h00, 8'h96, 8'h69, 8'h96, 8'h69, 0,
               16'h0, 16'h0, 16'h0};
    vec[5] = '{8'h13, 8'h10, 1, 8'h77, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1,
               mkw(7'h10, 8'h77), 16'h0, 16'h0};
    vec[6] = '{8'h04, 8'h05, 1, 8'h11, 8'h00, 8'hC5, 8'h00, 8'hC5, 8'h00, 0,
               16'h0, 16'h0, 16'h0};
    vec[7] = '{8'h03, 8'hFF, 1, 8'h00, 8'h00, 8'h00, 8'h00, 8'h7E, 8'h00, 2,
               mkr(7'h7F), mkr(7'h00), 16'h0};

    miso_cli = 1'b1;
    irq_loc = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs("por");
    $display("reset check done");
    miso_cli = 1'b0;
    irq_loc = 1'b0;
    rst_n = 1'b1;
    repeat (6) @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      if (vec[i].nstb > 0) exp_q.push_back(vec[i].s0);
      if (vec[i].nstb > 1) exp_q.push_back(vec[i].s1);
      if (vec[i].nstb > 2) exp_q.push_back(vec[i].s2);
      frame(vec[i].id, vec[i].cmd, vec[i].nb, vec[i].d0, vec[i].d1,
            vec[i].cli0, vec[i].cli1, m0, m1);
      if (vec[i].nb > 0) check($sformatf("v%0d_miso0", i), {24'd0, m0}, {24'd0, vec[i].miso0});
      if (vec[i].nb > 1) check($sformatf("v%0d_miso1", i), {24'd0, m1}, {24'd0, vec[i].miso1});
      check($sformatf("v%0d_drained", i), exp_q.size(), 32'd0);
      $display("frame %0d id=0x%02h cmd=0x%02h miso=0x%02h 0x%02h", i, vec[i].id, vec[i].cmd, m0, m1);
      exp_q.delete();
    end

    // Abort after 5 data bits, then a clean frame
    scsn = 1'b0;
    half();
    spi_byte(8'h03, 8'h00, 8, 1'b0, dummy);
    spi_byte(8'h05, 8'h00, 8, 1'b0, dummy);
    spi_byte(8'hFF, 8'h00, 5, 1'b0, dummy);
    half();
    scsn = 1'b1;
    mosi = 1'b0;
    repeat (3) half();
    check("abort_no_strobe", exp_q.size(), 32'd0);
    exp_q.push_back(mkw(7'h20, 8'h42));
    frame(8'h03, 8'h20, 1, 8'h42, 8'h00, 8'h00, 8'h00, m0, m1);
    check("after_abort_drained", exp_q.size(), 32'd0);
    $display("abort sequence done");
    exp_q.delete();

    // Reset pulsed mid-byte
    scsn = 1'b0;
    half();
    spi_byte(8'h03, 8'h00, 8, 1'b0, dummy);
    spi_byte(8'h05, 8'h00, 8, 1'b0, dummy);
    spi_byte(8'hF0, 8'h00, 3, 1'b0, dummy);
    miso_cli = 1'b1;
    irq_loc = 1'b1;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    scsn = 1'b1;
    sclk = 1'b0;
    mosi = 1'b0;
    miso_cli = 1'b0;
    irq_loc = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    exp_q.push_back(mkw(7'h06, 8'h99));
    frame(8'h03, 8'h06, 1, 8'h99, 8'h00, 8'h00, 8'h00, m0, m1);
    check("after_reset_drained", exp_q.size(), 32'd0);
    $display("mid-frame reset sequence done");
    exp_q.delete();

    // SCSN rises together with the 8th SCLK edge: byte still completes
    exp_q.push_back(mkw(7'h30, 8'h5C));
    scsn = 1'b0;
    half();
    spi_byte(8'h03, 8'h00, 8, 1'b0, dummy);
    spi_byte(8'h30, 8'h00, 8, 1'b0, dummy);
    spi_byte(8'h5C, 8'h00, 8, 1'b1, dummy);
    mosi = 1'b0;
    repeat (3) half();
    check("cs_last_edge_drained", exp_q.size(), 32'd0);
    $display("scsn-with-8th-edge sequence done");
    exp_q.delete();

    // Interrupt merge, one-cycle latency
    @(negedge clk);
    irq_cli = 1'b1;
    #1 check("irq_not_yet", {31'd0, irq_host}, 32'd0);
    @(negedge clk);
    check("irq_client", {31'd0, irq_host}, 32'd1);
    irq_cli = 1'b0;
    @(negedge clk);
    check("irq_clear", {31'd0, irq_host}, 32'd0);
    irq_loc = 1'b1;
    @(negedge clk);
    check("irq_local", {31'd0, irq_host}, 32'd1);
    irq_loc = 1'b0;
    @(negedge clk);
    check("irq_local_clear", {31'd0, irq_host}, 32'd0);
    $display("irq sequence done");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
